// File: rtl/sar_adc_sequencer.sv
// SAR conversion sequencer: issues conversion/calibration requests to the engine and buffers results in a FWFT FIFO.
// Build option SAR_SEQ_AVG4_EN: push the mean of every four conversions instead of each raw result.
module sar_adc_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 4,
    parameter int CAL_PERIOD = 1024,
    parameter int TIMEOUT    = 63
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic                        i_continuous,
    input  logic                        i_stop,
    input  logic                        i_cal_req,
    output logic                        o_adc_en,
    output logic                        o_adc_cal,
    input  logic                        i_adc_valid,
    input  logic [9:0]                  i_adc_result,
    input  logic                        i_rd_en,
    output logic [9:0]                  o_rd_data,
    output logic                        o_rd_empty,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
    output logic                        o_busy,
    output logic                        o_cal_done,
    output logic                        o_overflow,
    output logic                        o_timeout_err,
    input  logic                        i_clr_err,
    output logic [1:0]                  o_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int PW = (CAL_PERIOD > 1) ? $clog2(CAL_PERIOD) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]    r_state;
    logic          r_cal_pending;
    logic          r_is_cal;
    logic          r_owed;
    logic          r_cont;
    logic          r_stop_lat;
    logic          r_cal_done;
    logic          r_overflow;
    logic          r_timeout_err;
    logic [TW-1:0] r_timer;
    logic [GW-1:0] r_gap;
    logic [PW-1:0] r_conv_cnt;

    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic       w_in_wait;
    logic       w_conv_done;
    logic       w_cal_fin;
    logic       w_tmo;
    logic       w_gap_end;
    logic       w_more;
    logic       w_period_hit;
    logic       w_stop_clr;
    logic       w_push_req;
    logic [9:0] w_push_data;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;

    // Engine handshake: o_adc_en is a one-cycle request (o_adc_cal qualifies it);
    // the engine answers with a one-cycle i_adc_valid, honoured only while waiting.
    assign w_in_wait    = (r_state == S_WAIT);
    assign w_conv_done  = w_in_wait && i_adc_valid && !r_is_cal;
    assign w_cal_fin    = w_in_wait && i_adc_valid && r_is_cal;
    assign w_tmo        = w_in_wait && !i_adc_valid && (r_timer == TW'(TIMEOUT - 1));
    assign w_gap_end    = (r_state == S_GAP) && (r_gap == GW'(GAP_CYCLES - 1));
    assign w_more       = r_owed || (r_cont && !r_stop_lat);
    assign w_period_hit = (CAL_PERIOD != 0) && w_conv_done && (r_conv_cnt == PW'(CAL_PERIOD - 1));
    assign w_stop_clr   = w_tmo || ((w_cal_fin || w_gap_end) && !w_more);

`ifdef SAR_SEQ_AVG4_EN
    logic [11:0] r_acc;
    logic [1:0]  r_avg_cnt;
    logic [11:0] w_sum;

    assign w_sum       = r_acc + {2'b00, i_adc_result};
    assign w_push_req  = w_conv_done && (r_avg_cnt == 2'd3);
    assign w_push_data = w_sum[11:2];

    always_ff @(posedge clk) begin
        if (rst || w_cal_fin || w_tmo) begin
            r_acc     <= '0;
            r_avg_cnt <= '0;
        end else if (w_conv_done) begin
            r_acc     <= (r_avg_cnt == 2'd3) ? 12'd0 : w_sum;
            r_avg_cnt <= r_avg_cnt + 2'd1;
        end
    end
`else
    assign w_push_req  = w_conv_done;
    assign w_push_data = i_adc_result;
`endif

    assign w_full = (r_count == (AW + 1)'(FIFO_DEPTH));
    assign w_pop  = i_rd_en && (r_count != '0);
    assign w_push = w_push_req && (!w_full || w_pop);
    assign w_drop = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_gap    <= '0;
            r_is_cal <= 1'b0;
            r_owed   <= 1'b0;
            r_cont   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cont  <= i_continuous;
                        r_owed  <= 1'b1;
                        r_state <= S_ISSUE;
                    end else if (i_cal_req) begin
                        r_cont  <= 1'b0;
                        r_owed  <= 1'b0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_is_cal <= r_cal_pending;
                    r_timer  <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    r_gap   <= '0;
                    if (w_cal_fin) begin
                        r_state <= w_more ? S_GAP : S_IDLE;
                    end else if (w_conv_done) begin
                        r_owed  <= 1'b0;
                        r_state <= S_GAP;
                    end else if (w_tmo) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_gap <= r_gap + 1'b1;
                    if (w_gap_end) r_state <= w_more ? S_ISSUE : S_IDLE;
                end
            endcase
        end
    end

    // A new calibration request beats a same-cycle calibration completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cal_pending <= 1'b1;
            r_conv_cnt    <= '0;
            r_stop_lat    <= 1'b0;
            r_cal_done    <= 1'b0;
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_cal_done <= w_cal_fin;
            if (w_conv_done && (CAL_PERIOD != 0)) r_conv_cnt <= w_period_hit ? '0 : r_conv_cnt + 1'b1;
            if (i_cal_req || w_period_hit) r_cal_pending <= 1'b1;
            else if (w_cal_fin)            r_cal_pending <= 1'b0;
            if (w_stop_clr)                          r_stop_lat <= 1'b0;
            else if (i_stop && (r_state != S_IDLE))  r_stop_lat <= 1'b1;
            if (i_clr_err)   r_overflow <= 1'b0;
            else if (w_drop) r_overflow <= 1'b1;
            if (i_clr_err)  r_timeout_err <= 1'b0;
            else if (w_tmo) r_timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_adc_en      = (r_state == S_ISSUE);
    assign o_adc_cal     = (r_state == S_ISSUE) && r_cal_pending;
    assign o_rd_data     = (r_count == '0) ? 10'd0 : r_mem[r_rd_ptr];
    assign o_rd_empty    = (r_count == '0);
    assign o_fifo_count  = r_count;
    assign o_busy        = (r_state != S_IDLE);
    assign o_cal_done    = r_cal_done;
    assign o_overflow    = r_overflow;
    assign o_timeout_err = r_timeout_err;
    assign o_state       = r_state;

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Randomized bench for sar_adc_sequencer: engine responder plus a transaction-level model of calibration scheduling and the FIFO.
module tb_sar_adc_sequencer;
    localparam int DEPTH  = 8;
    localparam int GAP    = 4;
    localparam int PERIOD = 3;
    localparam int TMO    = 63;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0, i_continuous = 1'b0, i_stop = 1'b0, i_cal_req = 1'b0;
    logic       i_adc_valid = 1'b0, i_rd_en = 1'b0, i_clr_err = 1'b0;
    logic [9:0] i_adc_result = 10'd0;
    logic       o_adc_en, o_adc_cal, o_rd_empty, o_busy, o_cal_done, o_overflow, o_timeout_err;
    logic [9:0] o_rd_data;
    logic [3:0] o_fifo_count;
    logic [1:0] o_state;

    sar_adc_sequencer #(
        .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .CAL_PERIOD(PERIOD), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_continuous(i_continuous),
        .i_stop(i_stop), .i_cal_req(i_cal_req), .o_adc_en(o_adc_en), .o_adc_cal(o_adc_cal),
        .i_adc_valid(i_adc_valid), .i_adc_result(i_adc_result), .i_rd_en(i_rd_en),
        .o_rd_data(o_rd_data), .o_rd_empty(o_rd_empty), .o_fifo_count(o_fifo_count),
        .o_busy(o_busy), .o_cal_done(o_cal_done), .o_overflow(o_overflow),
        .o_timeout_err(o_timeout_err), .i_clr_err(i_clr_err), .o_state(o_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: what the sequencer should have done, in transaction terms.
    logic [9:0] exp_q[$];
    bit         m_pending;
    int         m_count;
    bit         m_overflow;
    bit         m_timeout;
    int         m_acc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pending  = 1'b1;
        m_count    = 0;
        m_overflow = 1'b0;
        m_timeout  = 1'b0;
        exp_q.delete();
        m_acc.delete();
    endtask

    task automatic model_conv(input logic [9:0] d, input bit pop);
        bit         do_push;
        logic [9:0] v;
        do_push = 1'b1;
        v = d;
        m_count++;
        if (PERIOD != 0 && m_count == PERIOD) begin
            m_pending = 1'b1;
            m_count   = 0;
        end
`ifdef SAR_SEQ_AVG4_EN
        m_acc.push_back(int'(d));
        do_push = 1'b0;
        if (m_acc.size() == 4) begin
            int s;
            s = 0;
            foreach (m_acc[k]) s += m_acc[k];
            v = 10'(s / 4);
            do_push = 1'b1;
            m_acc.delete();
        end
`endif
        if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (do_push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(v);
            else m_overflow = 1'b1;
        end
    endtask

    // Operations expected for a run of n conversions: calibrations slot in before a conversion when pending.
    function automatic int pred_ops(input int n);
        int ops;
        int c;
        ops = n + (m_pending ? 1 : 0);
        c = m_count;
        for (int j = 1; j < n; j++) begin
            c++;
            if (PERIOD != 0 && c == PERIOD) begin
                ops++;
                c = 0;
            end
        end
        return ops;
    endfunction

    task automatic check_fifo(input string tag);
        check({tag, "_cnt"}, 32'(o_fifo_count), exp_q.size());
        check({tag, "_head"}, 32'(o_rd_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
        check({tag, "_ovf"}, 32'(o_overflow), 32'(m_overflow));
    endtask

    task automatic do_start(input bit cont);
        i_start = 1'b1;
        i_continuous = cont;
        @(negedge clk);
        i_start = 1'b0;
        i_continuous = 1'b0;
    endtask

    // Engine responder: answers every request after a random latency until the sequencer goes idle.
    task automatic serve(input int n_conv, input int stop_at, input bit seq,
                         input logic [9:0] base, input bit pop_on_conv);
        int         ops, convs, guard, lat, exp_ops;
        bit         cal_op;
        logic [9:0] d;
        ops = 0; convs = 0; guard = 0;
        exp_ops = pred_ops(n_conv);
        while (guard < 3000) begin
            if (o_adc_en) begin
                ops++;
                cal_op = m_pending;
                check("issue_cal", 32'(o_adc_cal), 32'(cal_op));
                lat = $urandom_range(2, 6);
                @(negedge clk); guard++;
                if (!cal_op && stop_at != 0 && convs + 1 == stop_at) i_stop = 1'b1;
                repeat (lat - 1) begin
                    @(negedge clk); guard++;
                    i_stop = 1'b0;
                end
                d = seq ? base + 10'(convs) : 10'($urandom_range(0, 1023));
                i_adc_valid  = 1'b1;
                i_adc_result = d;
                i_rd_en      = pop_on_conv && !cal_op;
                @(negedge clk); guard++;
                i_adc_valid = 1'b0;
                i_rd_en     = 1'b0;
                if (cal_op) begin
                    m_pending = 1'b0;
                    m_acc.delete();
                end else begin
                    model_conv(d, pop_on_conv);
                    convs++;
                end
                check("cal_done", 32'(o_cal_done), 32'(cal_op));
                check_fifo("done");
            end else if (!o_busy) begin
                break;
            end else begin
                @(negedge clk); guard++;
            end
        end
        if (guard >= 3000) check("serve_bound", guard, 0);
        check("ops", ops, exp_ops);
        check("convs", convs, n_conv);
        check("busy_end", 32'(o_busy), 0);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 20) begin
            check("rd_head", 32'(o_rd_data), 32'(exp_q[0]));
            i_rd_en = 1'b1;
            @(negedge clk);
            i_rd_en = 1'b0;
            void'(exp_q.pop_front());
            check("rd_cnt", 32'(o_fifo_count), exp_q.size());
            g++;
        end
        i_rd_en = 1'b1;
        @(negedge clk);
        i_rd_en = 1'b0;
        check("empty_cnt", 32'(o_fifo_count), 0);
        check("empty_data", 32'(o_rd_data), 0);
        check("empty_flag", 32'(o_rd_empty), 1);
    endtask

    task automatic tmo_run(input bit clr_last);
        do_start(1'b0);
        check("tmo_issue", 32'(o_adc_en), 1);
        check("tmo_issue_cal", 32'(o_adc_cal), 32'(m_pending));
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk);
            if (i == TMO && clr_last) i_clr_err = 1'b1;
        end
        check("tmo_early", 32'(o_timeout_err), 0);
        check("tmo_wait", 32'(o_busy), 1);
        @(negedge clk);
        i_clr_err = 1'b0;
        if (!clr_last) m_timeout = 1'b1;
        m_acc.delete();
        check("tmo_err", 32'(o_timeout_err), 32'(m_timeout));
        check("tmo_idle", 32'(o_busy), 0);
        if (!clr_last) begin
            i_clr_err = 1'b1;
            @(negedge clk);
            i_clr_err = 1'b0;
            m_timeout = 1'b0;
            check("tmo_clr", 32'(o_timeout_err), 0);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_en", 32'(o_adc_en), 0);
        check("rst_cal", 32'(o_adc_cal), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_cal_done", 32'(o_cal_done), 0);
        check("rst_ovf", 32'(o_overflow), 0);
        check("rst_tmo", 32'(o_timeout_err), 0);
        check("rst_empty", 32'(o_rd_empty), 1);
        check("rst_cnt", 32'(o_fifo_count), 0);
        check("rst_data", 32'(o_rd_data), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single shot after reset: forced calibration then one conversion.
        do_start(1'b0);
        serve(1, 0, 1'b1, 10'h2A5, 1'b0);
`ifndef SAR_SEQ_AVG4_EN
        check("t1_data", 32'(o_rd_data), 32'h2A5);
        check("t1_cnt", 32'(o_fifo_count), 1);
`endif
        drain();

        // Continuous run of ten conversions with no reads: FIFO fills and overflows.
        do_start(1'b1);
        serve(10, 10, 1'b1, 10'd1, 1'b0);
`ifndef SAR_SEQ_AVG4_EN
        check("t2_ovf", 32'(o_overflow), 1);
        check("t2_cnt", 32'(o_fifo_count), 8);
        check("t2_head", 32'(o_rd_data), 1);
`endif

        // Push and pop together while full: no overflow, new result lands at the tail.
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
        m_overflow = 1'b0;
        check("clr_ovf", 32'(o_overflow), 0);
        do_start(1'b0);
        serve(1, 0, 1'b0, 10'd0, 1'b1);
        check("t3_ovf", 32'(o_overflow), 0);
        drain();

        tmo_run(1'b0);
        tmo_run(1'b1);

        // On-demand calibration from idle: calibration only, nothing pushed.
        i_cal_req = 1'b1;
        @(negedge clk);
        i_cal_req = 1'b0;
        m_pending = 1'b1;
        serve(0, 0, 1'b0, 10'd0, 1'b0);
        check("cal_only_cnt", 32'(o_fifo_count), 0);

        // Stop and adc_valid while idle are ignored.
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        check("idle_stop", 32'(o_busy), 0);
        i_adc_valid = 1'b1;
        i_adc_result = 10'h155;
        @(negedge clk);
        i_adc_valid = 1'b0;
        check("idle_valid_cnt", 32'(o_fifo_count), 0);
        check("idle_valid_empty", 32'(o_rd_empty), 1);

        for (int it = 0; it < 6; it++) begin
            bit cont;
            int n;
            cont = 1'($urandom_range(0, 1));
            n = cont ? $urandom_range(2, 5) : 1;
            do_start(cont);
            serve(n, cont ? n : 0, 1'b0, 10'd0, 1'b0);
            drain();
        end

        // Reset in the middle of a wait aborts with no push; calibration is owed again.
        do_start(1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("mid_rst_busy", 32'(o_busy), 0);
        check("mid_rst_cnt", 32'(o_fifo_count), 0);
        i_adc_valid = 1'b1;
        i_adc_result = 10'h3FF;
        @(negedge clk);
        i_adc_valid = 1'b0;
        check("mid_rst_novalid", 32'(o_fifo_count), 0);
        do_start(1'b0);
        serve(1, 0, 1'b0, 10'd0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
